seq_div_ctrl: RTL and testbench



---
 rtl/seq_div_pkg.sv | 19 +
 rtl/seq_div_ctrl_if.sv | 39 +++
 rtl/seq_div_ctrl_div_step.sv | 30 +++
 rtl/seq_div_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_div_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: controller state encoding, default width, iteration count and
// the quotient returned on a divide-by-zero.
package seq_div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_ITER  = DIV_WIDTH;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIN  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_div_ctrl_if.sv
// Start/busy/done handshake and operand/result bundle for seq_div_ctrl.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the divider is idle.
// Modports: master (opcode decoder side) drives start/operands; slave (divider)
// drives busy/done/results. signed_op exists only with SEQ_DIV_SIGNED_EN.
interface seq_div_ctrl_if
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SEQ_DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
`ifdef SEQ_DIV_SIGNED_EN
        output signed_op,
`endif
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef SEQ_DIV_SIGNED_EN
        input  signed_op,
`endif
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_div_ctrl_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D.
// Latency: combinational.
// Backpressure: none.
// Ports: r/q/d current remainder, quotient shift register, divisor;
// r_nxt/q_nxt next values; qbit the quotient bit produced by this step.
module div_step
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_nxt,
    output logic [WIDTH-1:0] q_nxt,
    output logic             qbit
);
    // The shifted partial remainder needs one extra bit: when D exceeds half
    // the range, R can have its MSB set and the shift would otherwise lose it.
    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    assign t    = {r, q[WIDTH-1]};
    assign diff = t - {1'b0, d};
    // No borrow out of the subtraction means T >= D.
    assign qbit  = ~diff[WIDTH];
    assign r_nxt = qbit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], qbit};

endmodule

// File: rtl/seq_div_ctrl.sv
// Sequencing controller for a restoring divider, one quotient bit per clock.
// Latency: done pulses WIDTH+1 edges after the accepting edge (1 for div-by-zero).
// Backpressure: start is ignored unless idle with no done pulse showing; not queued.
// Ports: clk, rst_n (async active-low), div (seq_div_ctrl_if.slave).
// Optional: SEQ_DIV_SIGNED_EN adds signed_op for truncating signed division.
module seq_div_ctrl
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_div_ctrl_if.slave div
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] DBZ_Q    = WIDTH'(DBZ_QUOTIENT);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;
    logic             dbz_q, done_q;
    logic             accept, last_iter, divisor_zero;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic             qbit;
    logic [WIDTH-1:0] mag_dividend, mag_divisor, quo_fix, rem_fix;

    assign divisor_zero = (div.divisor == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // done is registered one cycle behind FIN, so a start presented while
    // done is visible is refused explicitly here.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (div.start && !done_q) begin
                    accept    = 1'b1;
                    state_nxt = divisor_zero ? FIN : RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    last_iter = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r_q),
        .q     (q_q),
        .d     (d_q),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt),
        .qbit  (qbit)
    );

`ifdef SEQ_DIV_SIGNED_EN
    logic dvd_neg, dvs_neg, quo_neg_q, rem_neg_q;

    assign dvd_neg      = div.signed_op & div.dividend[WIDTH-1];
    assign dvs_neg      = div.signed_op & div.divisor[WIDTH-1];
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    assign mag_dividend = dvd_neg ? -div.dividend : div.dividend;
    assign mag_divisor  = dvs_neg ? -div.divisor  : div.divisor;
    assign quo_fix      = quo_neg_q ? -q_nxt : q_nxt;
    assign rem_fix      = rem_neg_q ? -r_nxt : r_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept && !divisor_zero) begin
            quo_neg_q <= dvd_neg ^ dvs_neg;
            rem_neg_q <= dvd_neg;
        end
    end
`else
    assign mag_dividend = div.dividend;
    assign mag_divisor  = div.divisor;
    assign quo_fix      = q_nxt;
    assign rem_fix      = r_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == FIN);
            if (accept) begin
                if (divisor_zero) begin
                    quotient_q  <= DBZ_Q;
                    remainder_q <= div.dividend;
                    dbz_q       <= 1'b1;
                end else begin
                    r_q   <= '0;
                    q_q   <= mag_dividend;
                    d_q   <= mag_divisor;
                    cnt_q <= '0;
                    dbz_q <= 1'b0;
                end
            end else if (state_q == RUN) begin
                r_q   <= r_nxt;
                q_q   <= {q_q[WIDTH-2:0], qbit};
                cnt_q <= cnt_q + 1'b1;
                // Results (with any sign fix) land on the FIN-entry edge.
                if (last_iter) begin
                    quotient_q  <= quo_fix;
                    remainder_q <= rem_fix;
                end
            end
        end
    end

    assign div.busy        = (state_q == RUN);
    assign div.done        = done_q;
    assign div.quotient    = quotient_q;
    assign div.remainder   = remainder_q;
    assign div.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_ctrl.sv
// Self-checking bench for seq_div_ctrl: directed boundaries plus random ops
// against an integer-arithmetic reference model. Build with SEQ_DIV_SIGNED_EN
// to also exercise signed division.
module tb_seq_div_ctrl;
    import seq_div_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_div_ctrl_if #(.WIDTH(DIV_WIDTH)) div_if ();

    seq_div_ctrl #(.WIDTH(DIV_WIDTH), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div   (div_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference: plain integer division (SV int '/' and '%' truncate toward 0).
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic sop,
                                  output logic [15:0] q, output logic [15:0] r, output logic z);
        int sa, sb, qi, ri;
        if (b == 16'd0) begin
            q = 16'hFFFF;
            r = a;
            z = 1'b1;
            return;
        end
        sa = sop ? int'($signed(a)) : int'(a);
        sb = sop ? int'($signed(b)) : int'(b);
        qi = sa / sb;
        ri = sa % sb;
        q  = qi[15:0];
        r  = ri[15:0];
        z  = 1'b0;
    endfunction

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic sop);
        @(negedge clk);
        div_if.start    = 1'b1;
        div_if.dividend = a;
        div_if.divisor  = b;
`ifdef SEQ_DIV_SIGNED_EN
        div_if.signed_op = sop;
`else
        if (sop) $display("note: signed_op requested in unsigned build");
`endif
        @(posedge clk);
        #1 div_if.start = 1'b0;
    endtask

    // k = number of edges after the accepting edge; -1 if done never seen.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (div_if.busy === 1'b1) busy_cnt++;
            if (div_if.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_op(input string name, input logic [15:0] a, input logic [15:0] b, input logic sop);
        logic [15:0] eq, er;
        logic ez;
        int lat, bc, exp_lat, exp_busy;
        model(a, b, sop, eq, er, ez);
        exp_lat  = ez ? 1 : 17;
        exp_busy = ez ? 0 : 16;
        drive_start(a, b, sop);
        wait_done(lat, bc);
        checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", name, lat, exp_lat); end
        checks++; if (bc !== exp_busy) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, bc, exp_busy); end
        checks++; if (div_if.quotient !== eq) begin failures++; $display("FAIL %s quotient got=%h exp=%h (a=%h b=%h s=%0b)", name, div_if.quotient, eq, a, b, sop); end
        checks++; if (div_if.remainder !== er) begin failures++; $display("FAIL %s remainder got=%h exp=%h (a=%h b=%h s=%0b)", name, div_if.remainder, er, a, b, sop); end
        checks++; if (div_if.div_by_zero !== ez) begin failures++; $display("FAIL %s div_by_zero got=%b exp=%b", name, div_if.div_by_zero, ez); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (div_if.done !== 1'b0) begin failures++; $display("FAIL %s done_pulse_width got=%b exp=0", name, div_if.done); end
        checks++; if (div_if.quotient !== eq) begin failures++; $display("FAIL %s quotient_hold got=%h exp=%h", name, div_if.quotient, eq); end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (div_if.busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", div_if.busy); end
        checks++; if (div_if.done !== 1'b0) begin failures++; $display("FAIL reset done got=%b exp=0", div_if.done); end
        checks++; if (div_if.quotient !== 16'h0) begin failures++; $display("FAIL reset quotient got=%h exp=0", div_if.quotient); end
        checks++; if (div_if.remainder !== 16'h0) begin failures++; $display("FAIL reset remainder got=%h exp=0", div_if.remainder); end
        checks++; if (div_if.div_by_zero !== 1'b0) begin failures++; $display("FAIL reset div_by_zero got=%b exp=0", div_if.div_by_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        test_op("basic_100_7", 16'd100, 16'd7, 1'b0);
        checks++; if (div_if.quotient !== 16'd14 || div_if.remainder !== 16'd2) begin
            failures++; $display("FAIL basic_const got=%0d r%0d exp=14 r2", div_if.quotient, div_if.remainder);
        end
    endtask

    task automatic test_boundaries();
        test_op("max_div_1", 16'hFFFF, 16'd1, 1'b0);
        test_op("small_div_big", 16'd5, 16'd9, 1'b0);
        test_op("zero_dividend", 16'd0, 16'd3, 1'b0);
        test_op("max_div_max", 16'hFFFF, 16'hFFFF, 1'b0);
        test_op("big_divisor", 16'hFFFE, 16'h8001, 1'b0);
    endtask

    task automatic test_div_zero();
        test_op("div_zero", 16'd1234, 16'd0, 1'b0);
        checks++; if (div_if.quotient !== 16'hFFFF || div_if.remainder !== 16'd1234) begin
            failures++; $display("FAIL dbz_const got=%h/%0d exp=ffff/1234", div_if.quotient, div_if.remainder);
        end
    endtask

    task automatic test_restart_ignored();
        int lat = -1;
        drive_start(16'd100, 16'd7, 1'b0);
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (k == 5) begin
                div_if.start = 1'b1;
                div_if.dividend = 16'd50;
                div_if.divisor = 16'd3;
            end else if (k == 6) begin
                div_if.start = 1'b0;
            end
            if (div_if.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 17) begin failures++; $display("FAIL restart latency got=%0d exp=17", lat); end
        checks++; if (div_if.quotient !== 16'd14 || div_if.remainder !== 16'd2) begin
            failures++; $display("FAIL restart result got=%0d r%0d exp=14 r2", div_if.quotient, div_if.remainder);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_start_held();
        int first = -1, second = -1;
        logic b18 = 1'bx, b19 = 1'bx;
        logic [15:0] q1 = 'x;
        @(negedge clk);
        div_if.start = 1'b1;
        div_if.dividend = 16'd200;
        div_if.divisor = 16'd10;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            if (k > 0) @(posedge clk);
            @(negedge clk);
            if (k == 18) b18 = div_if.busy;
            if (k == 19) begin
                b19 = div_if.busy;
                div_if.start = 1'b0;
                div_if.dividend = 16'd9;
                div_if.divisor = 16'd4;
            end
            if (div_if.done === 1'b1) begin
                if (first < 0) begin
                    first = k;
                    q1 = div_if.quotient;
                end else begin
                    second = k;
                    break;
                end
            end
        end
        checks++; if (first !== 17) begin failures++; $display("FAIL held first_done got=%0d exp=17", first); end
        checks++; if (q1 !== 16'd20) begin failures++; $display("FAIL held first_quotient got=%0d exp=20", q1); end
        checks++; if (b18 !== 1'b0) begin failures++; $display("FAIL held busy_in_done_cycle_after got=%b exp=0", b18); end
        checks++; if (b19 !== 1'b1) begin failures++; $display("FAIL held busy_after_idle_accept got=%b exp=1", b19); end
        checks++; if (second !== 36) begin failures++; $display("FAIL held second_done got=%0d exp=36", second); end
        checks++; if (div_if.quotient !== 16'd20 || div_if.remainder !== 16'd0) begin
            failures++; $display("FAIL held second_result got=%0d r%0d exp=20 r0", div_if.quotient, div_if.remainder);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        drive_start(16'd100, 16'd7, 1'b0);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (div_if.busy !== 1'b0) begin failures++; $display("FAIL rst_mid busy got=%b exp=0", div_if.busy); end
        checks++; if (div_if.quotient !== 16'h0 || div_if.remainder !== 16'h0) begin
            failures++; $display("FAIL rst_mid results got=%h/%h exp=0/0", div_if.quotient, div_if.remainder);
        end
        checks++; if (div_if.done !== 1'b0 || div_if.div_by_zero !== 1'b0) begin
            failures++; $display("FAIL rst_mid flags got=%b%b exp=00", div_if.done, div_if.div_by_zero);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (div_if.done === 1'b1 || div_if.busy === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rst_mid activity_after_reset got=%0d exp=0", dones); end
        test_op("rst_rerun", 16'd100, 16'd7, 1'b0);
    endtask

    task automatic test_signed();
`ifdef SEQ_DIV_SIGNED_EN
        test_op("s_neg100_7", 16'hFF9C, 16'd7, 1'b1);
        checks++; if (div_if.quotient !== 16'hFFF2 || div_if.remainder !== 16'hFFFE) begin
            failures++; $display("FAIL s_const got=%h/%h exp=fff2/fffe", div_if.quotient, div_if.remainder);
        end
        test_op("s_min_neg1", 16'h8000, 16'hFFFF, 1'b1);
        checks++; if (div_if.quotient !== 16'h8000 || div_if.remainder !== 16'h0) begin
            failures++; $display("FAIL s_min_const got=%h/%h exp=8000/0000", div_if.quotient, div_if.remainder);
        end
        test_op("s_7_neg2", 16'd7, 16'hFFFE, 1'b1);
        test_op("s_neg7_neg2", 16'hFFF9, 16'hFFFE, 1'b1);
        test_op("s_dbz", 16'hFF9C, 16'd0, 1'b1);
`endif
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic sop;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
`ifdef SEQ_DIV_SIGNED_EN
            sop = 1'($urandom_range(0, 1));
`else
            sop = 1'b0;
`endif
            test_op("random", a, b, sop);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        div_if.start    = 1'b0;
        div_if.dividend = '0;
        div_if.divisor  = '0;
`ifdef SEQ_DIV_SIGNED_EN
        div_if.signed_op = 1'b0;
`endif
        test_reset();
        test_basic();
        test_boundaries();
        test_div_zero();
        test_restart_ignored();
        test_start_held();
        test_reset_mid();
        test_signed();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
